// File: rtl/keccak_pkg.sv
// Shared types and widths for the keccak feeder logic.
//   pack_state_t : packer control states (accumulate, flush zero word, wait for drain)
//   WORD_W/BYTE_W/LANES : keccak word geometry
`timescale 1ns/1ps
package keccak_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LANES  = 4;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        WAIT  = 2'd2
    } pack_state_t;

endpackage

// File: rtl/keccak_byte_packer.sv
// Packs an 8-bit byte stream into the keccak core's 32-bit word interface.
// A message whose length is a multiple of 4 gets a trailing pad word with
// byte_num=0, is_last=1. One message per frame.
// Ports:
//   clk, reset (async, active-low)
//   s_byte/s_valid/s_last/s_ready : byte stream in (accepted on s_valid & s_ready)
//   in/in_ready/is_last/byte_num  : word out to keccak (consumed on in_ready & ~buffer_full)
//   buffer_full                   : keccak stall
//   msg_done                      : 1-cycle pulse after the final word is consumed
`timescale 1ns/1ps
module keccak_byte_packer
    import keccak_pkg::*;
#(
    parameter bit                MSB_FIRST = 1'b1,
    parameter logic [BYTE_W-1:0] PAD_BYTE  = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] s_byte,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [WORD_W-1:0] in,
    output logic              in_ready,
    output logic              is_last,
    output logic [1:0]        byte_num,
    input  logic              buffer_full,
    output logic              msg_done
);

    pack_state_t       state;
    logic [1:0]        cnt;
    logic [BYTE_W-1:0] acc [LANES-1];
    logic [WORD_W-1:0] word_c;
    logic              out_free_c;
    logic              accept_c;

    // Bit offset of byte lane idx inside the word.
    function automatic logic [4:0] lane_pos(input logic [1:0] idx);
        logic [1:0] lane;
        lane = MSB_FIRST ? ~idx : idx;
        return {lane, 3'b000};
    endfunction

    // Output register can take a new word: empty, or being consumed this edge.
    assign out_free_c = !in_ready || !buffer_full;
    assign s_ready    = reset && (state == ACC) && out_free_c;
    assign accept_c   = s_valid && s_ready;

    // Candidate word: stored bytes, the incoming byte in lane cnt, pad elsewhere.
    always_comb begin
        word_c = {LANES{PAD_BYTE}};
        for (int unsigned i = 0; i < LANES - 1; i++) begin
            if (2'(i) < cnt) begin
                word_c[lane_pos(2'(i)) +: BYTE_W] = acc[2'(i)];
            end
        end
        word_c[lane_pos(cnt) +: BYTE_W] = s_byte;
    end

    // Control state, accumulator and registered word interface.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ACC;
            cnt      <= 2'd0;
            for (int unsigned i = 0; i < LANES - 1; i++) acc[i] <= '0;
            in       <= '0;
            in_ready <= 1'b0;
            is_last  <= 1'b0;
            byte_num <= 2'd0;
            msg_done <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            // Drop valid on consumption; a load below on the same edge overrides.
            if (in_ready && !buffer_full) in_ready <= 1'b0;

            case (state)
                ACC: begin
                    if (accept_c) begin
                        if (cnt == 2'd3 || s_last) begin
                            in       <= word_c;
                            in_ready <= 1'b1;
                            // A last byte completing a full word defers is_last to the pad word.
                            is_last  <= s_last && (cnt != 2'd3);
                            byte_num <= (s_last && (cnt != 2'd3)) ? cnt + 2'd1 : 2'd0;
                            cnt      <= 2'd0;
                            if (s_last) state <= (cnt == 2'd3) ? FLUSH : WAIT;
                        end else begin
                            acc[cnt] <= s_byte;
                            cnt      <= cnt + 2'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (out_free_c) begin
                        in       <= {LANES{PAD_BYTE}};
                        in_ready <= 1'b1;
                        is_last  <= 1'b1;
                        byte_num <= 2'd0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (in_ready && !buffer_full) begin
                        msg_done <= 1'b1;
                        cnt      <= 2'd0;
                        state    <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Scoreboard bench for keccak_byte_packer: drivers push expected words,
// a negedge monitor pops and compares each consumed word and msg_done.
`timescale 1ns/1ps
module tb_keccak_byte_packer;
    import keccak_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_byte;
    logic        s_valid, s_last, s_ready;
    logic [31:0] in;
    logic        in_ready, is_last, buffer_full, msg_done;
    logic [1:0]  byte_num;

    logic [7:0]  l_s_byte;
    logic        l_s_valid, l_s_last, l_s_ready;
    logic [31:0] l_in;
    logic        l_in_ready, l_is_last, l_buffer_full, l_msg_done;
    logic [1:0]  l_byte_num;

    always #5 clk = ~clk;

    keccak_byte_packer #(.MSB_FIRST(1'b1), .PAD_BYTE(8'h00)) dut (
        .clk(clk), .reset(reset), .s_byte(s_byte), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .in(in), .in_ready(in_ready), .is_last(is_last),
        .byte_num(byte_num), .buffer_full(buffer_full), .msg_done(msg_done)
    );

    keccak_byte_packer #(.MSB_FIRST(1'b0), .PAD_BYTE(8'h00)) dut_lsb (
        .clk(clk), .reset(reset), .s_byte(l_s_byte), .s_valid(l_s_valid), .s_last(l_s_last),
        .s_ready(l_s_ready), .in(l_in), .in_ready(l_in_ready), .is_last(l_is_last),
        .byte_num(l_byte_num), .buffer_full(l_buffer_full), .msg_done(l_msg_done)
    );

    typedef struct packed {
        logic [31:0] word;
        logic        last;
        logic [1:0]  bn;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] w, input logic l, input logic [1:0] bn);
        exp_t x;
        x.word = w;
        x.last = l;
        x.bn   = bn;
        exp_q.push_back(x);
    endtask

    // Reference packing: big-endian lanes, zero pad, trailing pad word on multiples of 4.
    task automatic push_words(input string s);
        int n;
        int rem;
        logic [31:0] w;
        logic [7:0]  b;
        n   = s.len();
        rem = n % 4;
        for (int i = 0; i < n; i += 4) begin
            w = '0;
            for (int j = 0; j < 4; j++) begin
                b = (i + j < n) ? s[i + j] : 8'h00;
                w = {w[23:0], b};
            end
            if (i + 4 <= n) push_exp(w, 1'b0, 2'd0);
            else            push_exp(w, 1'b1, 2'(rem));
        end
        if (rem == 0) push_exp(32'h0, 1'b1, 2'd0);
    endtask

    // Monitor: compares each word on its consuming cycle and msg_done one cycle later.
    logic        exp_done = 1'b0;
    logic        holding  = 1'b0;
    logic [34:0] held;

    always @(negedge clk) begin
        if (!reset) begin
            exp_done = 1'b0;
            holding  = 1'b0;
        end else begin
            if (exp_done || msg_done) check("msg_done", 64'(msg_done), 64'(exp_done));
            exp_done = 1'b0;
            if (in_ready && buffer_full) begin
                check("stall_s_ready", 64'(s_ready), 64'(0));
                if (holding) check("held_word", 64'({in, is_last, byte_num}), 64'(held));
                held    = {in, is_last, byte_num};
                holding = 1'b1;
            end else begin
                holding = 1'b0;
            end
            if (in_ready && !buffer_full) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%h required=none", in);
                end else begin
                    e = exp_q.pop_front();
                    check("word", 64'({in, is_last, byte_num}), 64'(e));
                end
                if (is_last) exp_done = 1'b1;
            end
        end
    end

    task automatic send_bytes(input string s, input int cnt, input bit last_at_end, input bit bubbly);
        bit ok;
        for (int i = 0; i < cnt; i++) begin
            if (bubbly) begin
                repeat ($urandom_range(0, 3)) begin
                    s_valid = 1'b0;
                    s_last  = 1'($urandom_range(0, 1));
                    s_byte  = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            s_valid = 1'b1;
            s_byte  = s[i];
            s_last  = last_at_end && (i == cnt - 1);
            ok = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (s_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=no_accept required=accept byte=%0d", i);
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (msg_done) begin
                @(posedge clk); #1;
                return;
            end
            check("wait_s_ready", 64'(s_ready), 64'(0));
        end
        checks++;
        failures++;
        $display("FAIL done_timeout actual=no_msg_done required=msg_done");
    endtask

    // Stalls keccak for 10 cycles as soon as the second fox word ("quic") appears.
    task automatic stall_on_quic();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk); #1;
            if (in_ready && in == 32'h71756963) begin
                buffer_full = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                buffer_full = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL stall_trigger actual=not_seen required=quic_word");
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in"},       64'(in),       64'(0));
        check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        check({tag, "_is_last"},  64'(is_last),  64'(0));
        check({tag, "_byte_num"}, 64'(byte_num), 64'(0));
        check({tag, "_msg_done"}, 64'(msg_done), 64'(0));
        check({tag, "_s_ready"},  64'(s_ready),  64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        s_byte = '0; s_valid = 1'b0; s_last = 1'b0; buffer_full = 1'b0;
        l_s_byte = '0; l_s_valid = 1'b0; l_s_last = 1'b0; l_buffer_full = 1'b0;
        #12;
        check_all_zero("rst");
        check("rst_lsb_in_ready", 64'(l_in_ready), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // 13 bytes: three full words plus partial "!"
        push_exp(32'h48656c6c, 1'b0, 2'd0);
        push_exp(32'h6f2c2077, 1'b0, 2'd0);
        push_exp(32'h6f726c64, 1'b0, 2'd0);
        push_exp(32'h21000000, 1'b1, 2'd1);
        send_bytes("Hello, world!", 13, 1'b1, 1'b0);
        wait_done();

        // 12 bytes: multiple of 4 -> pad word
        push_words("Hello, world");
        send_bytes("Hello, world", 12, 1'b1, 1'b0);
        wait_done();

        // 44 bytes with a 10-cycle stall on the second word
        push_words("The quick brown fox jumps over the lazy dog.");
        fork
            send_bytes("The quick brown fox jumps over the lazy dog.", 44, 1'b1, 1'b0);
            stall_on_quic();
        join
        wait_done();

        // Single byte, MSB-first
        push_exp(32'h41000000, 1'b1, 2'd1);
        send_bytes("A", 1, 1'b1, 1'b0);
        wait_done();

        // Single byte, LSB-first instance
        l_s_byte = 8'h41; l_s_valid = 1'b1; l_s_last = 1'b1;
        @(negedge clk);
        check("lsb_s_ready", 64'(l_s_ready), 64'(1));
        @(posedge clk); #1;
        l_s_valid = 1'b0; l_s_last = 1'b0;
        @(negedge clk);
        check("lsb_word", 64'({l_in, l_in_ready, l_is_last, l_byte_num}),
              64'({32'h00000041, 1'b1, 1'b1, 2'd1}));
        @(negedge clk);
        check("lsb_msg_done", 64'(l_msg_done), 64'(1));
        @(posedge clk); #1;

        // Reset mid-message discards the half-built word
        push_exp(32'h70617373, 1'b0, 2'd0);
        send_bytes("password123", 6, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        push_exp(32'h31323334, 1'b0, 2'd0);
        push_exp(32'h35363738, 1'b0, 2'd0);
        push_exp(32'h39300000, 1'b1, 2'd2);
        send_bytes("1234567890", 10, 1'b1, 1'b0);
        wait_done();

        // Same message gapless, then with random bubbles
        push_words("Testing 1, 2, 3.");
        send_bytes("Testing 1, 2, 3.", 16, 1'b1, 1'b0);
        wait_done();
        push_words("Testing 1, 2, 3.");
        send_bytes("Testing 1, 2, 3.", 16, 1'b1, 1'b1);
        wait_done();

        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
